alu: RTL and testbench



---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_div4.sv | 34 +++
 rtl/alu.sv | 92 +++++++++
 tb/tb_alu.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types and constants.
// Optional error counter is enabled with macro ALU_ERRCNT_EN.
package alu_pkg;

  localparam int W = 4;
  localparam int PW = 2 * W;
  localparam int CNT_W = 16;

  localparam logic [W-1:0] DZ_RESULT = 4'hF;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    DIV = 2'b11
  } op_e;

endpackage

// File: rtl/alu_div4.sv
// Combinational restoring divider, one stage per quotient bit.
// Divide-by-zero forces the all-ones quotient.
module alu_div4
  import alu_pkg::*;
(
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         dz
);

  logic [W:0]   rem;
  logic [W+1:0] trial;
  logic [W-1:0] q;

  always_comb begin
    rem   = '0;
    trial = '0;
    q     = '0;
    for (int i = W - 1; i >= 0; i--) begin
      rem   = {rem[W-1:0], dividend[i]};
      trial = {1'b0, rem} - {2'b00, divisor};
      // top bit set means the trial subtraction borrowed: restore
      if (!trial[W+1]) begin
        rem  = trial[W:0];
        q[i] = 1'b1;
      end
    end
  end

  assign dz       = (divisor == '0);
  assign quotient = dz ? DZ_RESULT : q;

endmodule

// File: rtl/alu.sv
// 4-bit unsigned ALU: add/sub/mul/div, registered result.
// Define ALU_ERRCNT_EN to add the saturating divide-by-zero counter.
module alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [1:0]       Op,
  output logic [W-1:0]     C,
  output logic [W-1:0]     C_q,
  output logic             ovf,
`ifdef ALU_ERRCNT_EN
  output logic             dz,
  output logic [CNT_W-1:0] err_cnt
`else
  output logic             dz
`endif
);

  logic [W:0]    sum;
  logic [W:0]    diff;
  logic [PW-1:0] prod;
  logic [W-1:0]  div_q;
  logic          div_dz;
  op_e           op;

  assign op   = op_e'(Op);
  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  // shift-and-add array: one partial product per bit of B
  always_comb begin
    prod = '0;
    for (int i = 0; i < W; i++) begin
      if (B[i]) begin
        prod = prod + ({{W{1'b0}}, A} << i);
      end
    end
  end

  alu_div4 u_div (
    .dividend (A),
    .divisor  (B),
    .quotient (div_q),
    .dz       (div_dz)
  );

  always_comb begin
    C   = '0;
    ovf = 1'b0;
    dz  = 1'b0;
    unique case (op)
      ADD: begin
        C   = sum[W-1:0];
        ovf = sum[W];
      end
      SUB: begin
        C   = diff[W-1:0];
        ovf = diff[W];
      end
      MUL: begin
        C   = prod[W-1:0];
        ovf = |prod[PW-1:W];
      end
      DIV: begin
        C  = div_q;
        dz = div_dz;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      C_q <= '0;
    end else begin
      C_q <= C;
    end
  end

`ifdef ALU_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (dz && err_cnt != CNT_MAX) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu.sv
// Directed and exhaustive self-checking bench for alu.
// Counter checks are compiled in with ALU_ERRCNT_EN.
module tb_alu;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] Op;
  logic [3:0] C;
  logic [3:0] C_q;
  logic       ovf;
  logic       dz;
`ifdef ALU_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  int checks;
  int errors;

  alu dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .Op      (Op),
    .C       (C),
    .C_q     (C_q),
    .ovf     (ovf),
`ifdef ALU_ERRCNT_EN
    .dz      (dz),
    .err_cnt (err_cnt)
`else
    .dz      (dz)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic vec(input string tag,
                     input logic [3:0] a, input logic [3:0] b,
                     input logic [1:0] op, input logic [3:0] ec,
                     input logic eo, input logic ed);
    A  = a;
    B  = b;
    Op = op;
    #1;
    check({tag, "_c"}, 16'(C), 16'(ec));
    check({tag, "_ovf"}, 16'(ovf), 16'(eo));
    check({tag, "_dz"}, 16'(dz), 16'(ed));
  endtask

  initial begin
    int r;
    logic [3:0] ec;
    logic       eo;
    logic       ed;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    A   = '0;
    B   = '0;
    Op  = 2'b00;
    #1;
    check("rst_cq", 16'(C_q), 16'h0);
`ifdef ALU_ERRCNT_EN
    check("rst_cnt", err_cnt, 16'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    vec("add_3_5", 4'd3, 4'd5, 2'b00, 4'd8, 1'b0, 1'b0);
    vec("add_9_9", 4'd9, 4'd9, 2'b00, 4'd2, 1'b1, 1'b0);
    vec("sub_2_5", 4'd2, 4'd5, 2'b01, 4'd13, 1'b1, 1'b0);
    vec("sub_7_7", 4'd7, 4'd7, 2'b01, 4'd0, 1'b0, 1'b0);
    vec("mul_7_3", 4'd7, 4'd3, 2'b10, 4'd5, 1'b1, 1'b0);
    vec("mul_0_1", 4'd0, 4'd1, 2'b10, 4'd0, 1'b0, 1'b0);
    vec("mul_f_f", 4'd15, 4'd15, 2'b10, 4'd1, 1'b1, 1'b0);
    vec("div_13_4", 4'd13, 4'd4, 2'b11, 4'd3, 1'b0, 1'b0);
    vec("div_15_1", 4'd15, 4'd1, 2'b11, 4'd15, 1'b0, 1'b0);
    vec("div_9_0", 4'd9, 4'd0, 2'b11, 4'd15, 1'b0, 1'b1);
    vec("add_b0", 4'd4, 4'd0, 2'b00, 4'd4, 1'b0, 1'b0);

    // registered path and async reset
    @(negedge clk);
    vec("pre_reg", 4'd5, 4'd1, 2'b00, 4'd6, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("cq_load", 16'(C_q), 16'h6);
    #2;
    rst = 1'b1;
    #1;
    check("cq_async_rst", 16'(C_q), 16'h0);
    check("c_during_rst", 16'(C), 16'h6);
    check("ovf_during_rst", 16'(ovf), 16'h0);
`ifdef ALU_ERRCNT_EN
    check("cnt_async_rst", err_cnt, 16'h0);
`endif

    // divide-by-zero held for three edges after reset release
    A  = 4'd9;
    B  = 4'd0;
    Op = 2'b11;
    @(negedge clk);
    check("dz_during_rst", 16'(dz), 16'h1);
    check("cq_held_rst", 16'(C_q), 16'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("cq_first_edge", 16'(C_q), 16'hF);
`ifdef ALU_ERRCNT_EN
    check("cnt_1", err_cnt, 16'd1);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
`ifdef ALU_ERRCNT_EN
    check("cnt_3", err_cnt, 16'd3);
`endif
    @(negedge clk);
    B = 4'd3;
    @(posedge clk);
    #1;
    check("cq_div_9_3", 16'(C_q), 16'h3);
`ifdef ALU_ERRCNT_EN
    check("cnt_hold", err_cnt, 16'd3);
`endif

    // exhaustive sweep against arithmetic reference
    for (int a = 0; a < 16; a++) begin
      for (int op = 0; op < 4; op++) begin
        for (int b = 0; b < 16; b++) begin
          ed = 1'b0;
          eo = 1'b0;
          case (op)
            0: begin r = a + b; eo = (r > 15); end
            1: begin r = a - b; eo = (a < b); end
            2: begin r = a * b; eo = (r > 15); end
            default: begin
              if (b == 0) begin
                r  = 15;
                ed = 1'b1;
              end else begin
                r = a / b;
              end
            end
          endcase
          ec = r[3:0];
          vec($sformatf("sw_a%0d_op%0d_b%0d", a, op, b),
              4'(a), 4'(b), 2'(op), ec, eo, ed);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
